// File: rtl/bnn_pkg.sv
// bnn_pkg: image geometry and buffer FSM states shared by the byte buffer, BNN interface and controller.
package bnn_pkg;
    localparam int NUM_BYTES = 113;
    localparam int IMG_BITS = NUM_BYTES * 8;
    typedef enum logic [1:0] {IDLE, FILL, CHECK, FULL} buf_state_t;
endpackage

// File: rtl/img_byte_buffer.sv
// img_byte_buffer: assembles a 113-byte image from a byte stream into a parallel register for the BNN.
// BUF_CHECKSUM_EN adds a trailing XOR checksum byte verified in the CHECK state.
module img_byte_buffer
    import bnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                buffer_clear,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic [6:0]          byte_count,
    output logic                overflow,
    output logic                checksum_err
);
    buf_state_t state, state_n;
    logic accept, last;
    logic [9:0] pos;
    assign rx_ready = (state != FULL);
    assign img_buffer_full = (state == FULL);
    assign accept = rx_valid && rx_ready && !buffer_clear;
    assign last = (byte_count == 7'(NUM_BYTES - 1));
    assign pos = 10'(IMG_BITS - 8) - {byte_count, 3'b000};
`ifdef BUF_CHECKSUM_EN
    localparam buf_state_t DONE = CHECK;
    logic [7:0] acc;
    logic sum_ok;
    assign sum_ok = (rx_byte == acc);
    always_ff @(posedge clk) begin
        if (rst || buffer_clear) begin
            acc <= '0;
            checksum_err <= 1'b0;
        end else if (accept) begin
            acc <= (state == CHECK) ? 8'h00 : acc ^ rx_byte;
            if (state == CHECK && !sum_ok) checksum_err <= 1'b1;
        end
    end
`else
    localparam buf_state_t DONE = FULL;
    assign checksum_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (buffer_clear) state_n = IDLE;
        else if (accept)
            case (state)
                IDLE, FILL: state_n = last ? DONE : FILL;
`ifdef BUF_CHECKSUM_EN
                CHECK: state_n = sum_ok ? FULL : IDLE;
`endif
                default: state_n = state;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            img_out <= '0;
            byte_count <= '0;
            overflow <= 1'b0;
        end else if (buffer_clear) begin
            byte_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (rx_valid && state == FULL) overflow <= 1'b1;
            if (accept && state != CHECK) begin
                img_out[pos +: 8] <= rx_byte;
                byte_count <= byte_count + 7'(byte_count != 7'(NUM_BYTES));
            end
`ifdef BUF_CHECKSUM_EN
            if (accept && state == CHECK && !sum_ok) byte_count <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_img_byte_buffer.sv
// tb_img_byte_buffer: directed frames; a monitor compares img_out against queued images on each rise of img_buffer_full.
module tb_img_byte_buffer;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] rx_byte = '0;
    logic rx_valid = 1'b0, buffer_clear = 1'b0;
    logic rx_ready, img_buffer_full, overflow, checksum_err;
    logic [903:0] img_out;
    logic [6:0] byte_count;
    logic [903:0] sb[$];
    logic [903:0] exp_img;
    logic prev_full = 1'b0;
    int compared = 0, mismatched = 0;

    img_byte_buffer dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .buffer_clear(buffer_clear), .img_out(img_out), .img_buffer_full(img_buffer_full),
        .byte_count(byte_count), .overflow(overflow), .checksum_err(checksum_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic chk_img(input string nm, input logic [903:0] act, input logic [903:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            for (int i = 0; i < 113; i++)
                if (act[903-8*i -: 8] !== req[903-8*i -: 8]) begin
                    $display("FAIL %s: byte %0d got %0h expected %0h", nm, i, act[903-8*i -: 8], req[903-8*i -: 8]);
                    break;
                end
        end
    endtask

    always @(negedge clk) begin
        if (img_buffer_full && !prev_full) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_full: got full=1 expected no frame");
            end else chk_img("frame", img_out, sb.pop_front());
        end
        prev_full <= img_buffer_full;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic clear();
        buffer_clear = 1'b1;
        @(posedge clk);
        #1 buffer_clear = 1'b0;
    endtask

    task automatic send_const(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_count", 32'(byte_count), 0);
        chk("rst_full", 32'(img_buffer_full), 0);
        chk("rst_ready", 32'(rx_ready), 1);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_cerr", 32'(checksum_err), 0);
        chk_img("rst_img", img_out, '0);

        // T1: ramp 0x00..0x70
        for (int i = 0; i < 113; i++) exp_img[903-8*i -: 8] = 8'(i);
        sb.push_back(exp_img);
        for (int i = 0; i < 112; i++) send_byte(8'(i));
        chk("t1_count112", 32'(byte_count), 112);
        chk("t1_notfull", 32'(img_buffer_full), 0);
        send_byte(8'h70);
`ifdef BUF_CHECKSUM_EN
        chk("t1_notfull_chk", 32'(img_buffer_full), 0);
        send_byte(8'h70);
`endif
        chk("t1_full", 32'(img_buffer_full), 1);
        chk("t1_count", 32'(byte_count), 113);
        chk("t1_first", 32'(img_out[903:896]), 0);
        chk("t1_last", 32'(img_out[7:0]), 32'h70);
        chk("t1_ready", 32'(rx_ready), 0);

        // T2: overflow while full, then clear
        send_const(8'hEE, 3);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_count", 32'(byte_count), 113);
        chk_img("t2_img_hold", img_out, exp_img);
        clear();
        chk("t2_clr_ovf", 32'(overflow), 0);
        chk("t2_clr_full", 32'(img_buffer_full), 0);
        chk("t2_clr_count", 32'(byte_count), 0);
        chk("t2_clr_ready", 32'(rx_ready), 1);
        chk_img("t2_img_kept", img_out, exp_img);

        // T3: partial frame abandoned, then all-ones frame
        send_const(8'h11, 50);
        chk("t3_count50", 32'(byte_count), 50);
        clear();
        chk("t3_clr_count", 32'(byte_count), 0);
        exp_img = '1;
        sb.push_back(exp_img);
        send_const(8'hFF, 113);
`ifdef BUF_CHECKSUM_EN
        send_byte(8'hFF);
`endif
        chk("t3_full", 32'(img_buffer_full), 1);
        chk_img("t3_img", img_out, exp_img);

        // T4: clear and byte together in IDLE
        clear();
        buffer_clear = 1'b1;
        send_byte(8'hAB);
        buffer_clear = 1'b0;
        chk("t4_count", 32'(byte_count), 0);
        chk("t4_first", 32'(img_out[903:896]), 32'hFF);
        chk("t4_full", 32'(img_buffer_full), 0);

`ifdef BUF_CHECKSUM_EN
        // T5: 113 x 0x5A XORs to 0x5A
        exp_img = {113{8'h5A}};
        sb.push_back(exp_img);
        send_const(8'h5A, 113);
        send_byte(8'h5A);
        chk("t5_full", 32'(img_buffer_full), 1);
        chk("t5_cerr0", 32'(checksum_err), 0);
        clear();
        send_const(8'h5A, 113);
        send_byte(8'h00);
        chk("t5_cerr1", 32'(checksum_err), 1);
        chk("t5_nofull", 32'(img_buffer_full), 0);
        chk("t5_count", 32'(byte_count), 0);
        chk("t5_ready", 32'(rx_ready), 1);
        clear();
        chk("t5_clr_cerr", 32'(checksum_err), 0);
`endif

        // T6: reset in the middle of a frame
        send_const(8'h3C, 59);
        rst = 1'b1;
        send_byte(8'h3C);
        rst = 1'b0;
        chk("t6_count", 32'(byte_count), 0);
        chk("t6_full", 32'(img_buffer_full), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_cerr", 32'(checksum_err), 0);
        chk("t6_ready", 32'(rx_ready), 1);
        chk_img("t6_img", img_out, '0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
